// File: rtl/st_irq_arbiter.sv
// st_irq_arbiter: Atari ST GLUE interrupt function.
// Latches HBL/VBL events, encodes them with the MFP request onto the 68000 IPL
// lines, and sequences interrupt-acknowledge cycles (vectored MFP, autovector,
// or bus error).
module st_irq_arbiter #(
   parameter int unsigned IACK_WAIT   = 2,
   parameter int unsigned ACK_TIMEOUT = 31
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       hbl_in,
   input  logic       vbl_in,
   input  logic       mfp_irq,
   input  logic [2:0] cpu_fc,
   input  logic [2:0] cpu_addr,
   input  logic       cpu_as_n,
   output logic [2:0] cpu_ipl_n,
   output logic       mfp_iack,
   output logic       dtack_n,
   output logic       vpa_n,
   output logic       berr_n
);

   localparam int unsigned CW = $clog2(ACK_TIMEOUT + 1);
   localparam logic [CW-1:0] WAIT_LAST = CW'(IACK_WAIT - 1);
   localparam logic [CW-1:0] TMO_LAST  = CW'(ACK_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DECODE,
      S_MFP_WAIT,
      S_MFP_ACK,
      S_AUTO,
      S_SPUR,
      S_DONE
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] tmo_q, tmo_d;
   logic          hbl_q, vbl_q;
   logic          hbl_pend_q, hbl_pend_d;
   logic          vbl_pend_q, vbl_pend_d;
   logic [2:0]    ipl_q, ipl_d;
   logic          mfp_iack_q, mfp_iack_d;
   logic          dtack_n_q, dtack_n_d;
   logic          vpa_n_q, vpa_n_d;
   logic          berr_n_q, berr_n_d;
   logic          clr_hbl, clr_vbl;
   logic          iack_cyc;

   assign iack_cyc = (cpu_fc == 3'b111) && !cpu_as_n;

   // Pending flags: a new rising edge wins over an acknowledge clear in the same cycle.
   always_comb begin
      hbl_pend_d = (hbl_in & ~hbl_q) | (hbl_pend_q & ~clr_hbl);
      vbl_pend_d = (vbl_in & ~vbl_q) | (vbl_pend_q & ~clr_vbl);
   end

   // Priority encode of the three interrupt sources onto the active-low IPL lines.
   always_comb begin
      ipl_d = 3'b111;
      if (mfp_irq)
         ipl_d = ~3'd6;
      else if (vbl_pend_q)
         ipl_d = ~3'd4;
      else if (hbl_pend_q)
         ipl_d = ~3'd2;
   end

   // Acknowledge sequencer: next state, ack timer and pend-clear strobes.
   // The timer runs across MFP_WAIT into MFP_ACK so the timeout is measured
   // from the start of the MFP acknowledge, and also paces the MFP vector settle.
   always_comb begin
      state_d = state_q;
      tmo_d   = '0;
      clr_hbl = 1'b0;
      clr_vbl = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (iack_cyc)
               state_d = S_DECODE;
         end
         S_DECODE: begin
            clr_hbl = (cpu_addr == 3'd2);
            clr_vbl = (cpu_addr == 3'd4);
            if (cpu_as_n)
               state_d = S_DONE;
            else if (cpu_addr == 3'd6)
               state_d = S_MFP_WAIT;
            else if ((cpu_addr == 3'd4) || (cpu_addr == 3'd2))
               state_d = S_AUTO;
            else
               state_d = S_SPUR;
         end
         S_MFP_WAIT: begin
            tmo_d = tmo_q + 1'b1;
            if (cpu_as_n)
               state_d = S_DONE;
            else if (tmo_q == TMO_LAST)
               state_d = S_SPUR;
            else if (tmo_q == WAIT_LAST)
               state_d = S_MFP_ACK;
         end
         S_MFP_ACK, S_AUTO: begin
            tmo_d = tmo_q + 1'b1;
            if (cpu_as_n)
               state_d = S_DONE;
            else if (tmo_q == TMO_LAST)
               state_d = S_SPUR;
         end
         S_SPUR: begin
            if (cpu_as_n)
               state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Bus strobes decoded from the next state and registered, so they are glitch-free.
   always_comb begin
      mfp_iack_d = (state_d == S_MFP_WAIT) || (state_d == S_MFP_ACK);
      dtack_n_d  = (state_d != S_MFP_ACK);
      vpa_n_d    = (state_d != S_AUTO);
      berr_n_d   = (state_d != S_SPUR);
   end

   // State, edge-detect, pending and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         tmo_q      <= '0;
         hbl_q      <= hbl_in;
         vbl_q      <= vbl_in;
         hbl_pend_q <= 1'b0;
         vbl_pend_q <= 1'b0;
         ipl_q      <= 3'b111;
         mfp_iack_q <= 1'b0;
         dtack_n_q  <= 1'b1;
         vpa_n_q    <= 1'b1;
         berr_n_q   <= 1'b1;
      end else begin
         state_q    <= state_d;
         tmo_q      <= tmo_d;
         hbl_q      <= hbl_in;
         vbl_q      <= vbl_in;
         hbl_pend_q <= hbl_pend_d;
         vbl_pend_q <= vbl_pend_d;
         ipl_q      <= ipl_d;
         mfp_iack_q <= mfp_iack_d;
         dtack_n_q  <= dtack_n_d;
         vpa_n_q    <= vpa_n_d;
         berr_n_q   <= berr_n_d;
      end
   end

   assign cpu_ipl_n = ipl_q;
   assign mfp_iack  = mfp_iack_q;
   assign dtack_n   = dtack_n_q;
   assign vpa_n     = vpa_n_q;
   assign berr_n    = berr_n_q;

endmodule

// File: tb/tb_st_irq_arbiter.sv
// Bench for st_irq_arbiter. Each scenario queues per-cycle stimulus with the
// hand-derived expected outputs {cpu_ipl_n, mfp_iack, dtack_n, vpa_n, berr_n};
// expectations are pushed to a scoreboard as stimulus is driven and popped
// after the following clock edge.
module tb_st_irq_arbiter;

   logic       clk = 1'b0;
   logic       reset;
   logic       hbl_in, vbl_in, mfp_irq;
   logic [2:0] cpu_fc, cpu_addr;
   logic       cpu_as_n;
   logic [2:0] cpu_ipl_n;
   logic       mfp_iack, dtack_n, vpa_n, berr_n;

   typedef struct {
      logic       rst;
      logic       hbl;
      logic       vbl;
      logic       irq;
      logic [2:0] fc;
      logic [2:0] addr;
      logic       as_n;
      logic [6:0] exp;
   } vec_t;

   vec_t       stim_q[$];
   logic [6:0] exp_q[$];
   int         vectors = 0;
   int         miscompares = 0;

   st_irq_arbiter #(.IACK_WAIT(2), .ACK_TIMEOUT(31)) dut (
      .clk       (clk),
      .reset     (reset),
      .hbl_in    (hbl_in),
      .vbl_in    (vbl_in),
      .mfp_irq   (mfp_irq),
      .cpu_fc    (cpu_fc),
      .cpu_addr  (cpu_addr),
      .cpu_as_n  (cpu_as_n),
      .cpu_ipl_n (cpu_ipl_n),
      .mfp_iack  (mfp_iack),
      .dtack_n   (dtack_n),
      .vpa_n     (vpa_n),
      .berr_n    (berr_n)
   );

   always #5 clk = ~clk;

   function automatic void add(input logic rst, input logic hbl, input logic vbl,
                               input logic irq, input logic [2:0] fc,
                               input logic [2:0] addr, input logic as_n,
                               input logic [6:0] exp);
      vec_t v;
      v.rst = rst; v.hbl = hbl; v.vbl = vbl; v.irq = irq;
      v.fc = fc; v.addr = addr; v.as_n = as_n; v.exp = exp;
      stim_q.push_back(v);
   endfunction

   task automatic drive(input vec_t v);
      reset = v.rst; hbl_in = v.hbl; vbl_in = v.vbl; mfp_irq = v.irq;
      cpu_fc = v.fc; cpu_addr = v.addr; cpu_as_n = v.as_n;
   endtask

   // Reset with vbl_in high through release: no VBL event may appear afterwards.
   task automatic test_reset();
      vec_t v; logic [6:0] e, got; int n = 0;
      add(1, 0, 1, 0, 0, 0, 1, 7'b111_0111);
      add(1, 0, 1, 0, 0, 0, 1, 7'b111_0111);
      add(0, 0, 1, 0, 0, 0, 1, 7'b111_0111);
      add(0, 0, 1, 0, 0, 0, 1, 7'b111_0111);
      add(0, 0, 0, 0, 0, 0, 1, 7'b111_0111);
      while (stim_q.size() != 0) begin
         v = stim_q.pop_front(); drive(v); exp_q.push_back(v.exp);
         @(posedge clk); #1;
         e = exp_q.pop_front(); got = {cpu_ipl_n, mfp_iack, dtack_n, vpa_n, berr_n};
         vectors++;
         if (got !== e) begin
            miscompares++;
            $display("FAIL reset vec %0d: ipl/iack/dtack/vpa/berr got %b required %b", n, got, e);
         end
         n++;
      end
   endtask

   // HBL event -> level 2, autovector acknowledge clears it.
   task automatic test_hbl_auto();
      vec_t v; logic [6:0] e, got; int n = 0;
      add(0, 1, 0, 0, 0, 0, 1, 7'b111_0111);
      add(0, 1, 0, 0, 0, 0, 1, 7'b101_0111);
      add(0, 0, 0, 0, 7, 2, 0, 7'b101_0111);
      add(0, 0, 0, 0, 7, 2, 0, 7'b101_0101);
      add(0, 0, 0, 0, 7, 2, 0, 7'b111_0101);
      add(0, 0, 0, 0, 0, 0, 1, 7'b111_0111);
      add(0, 0, 0, 0, 0, 0, 1, 7'b111_0111);
      while (stim_q.size() != 0) begin
         v = stim_q.pop_front(); drive(v); exp_q.push_back(v.exp);
         @(posedge clk); #1;
         e = exp_q.pop_front(); got = {cpu_ipl_n, mfp_iack, dtack_n, vpa_n, berr_n};
         vectors++;
         if (got !== e) begin
            miscompares++;
            $display("FAIL hbl_auto vec %0d: ipl/iack/dtack/vpa/berr got %b required %b", n, got, e);
         end
         n++;
      end
   endtask

   // MFP over pending VBL: vectored ack, VBL survives, then level-4 autovector clears it.
   task automatic test_mfp_vectored();
      vec_t v; logic [6:0] e, got; int n = 0;
      add(0, 0, 1, 1, 0, 0, 1, 7'b001_0111);
      add(0, 0, 1, 1, 0, 0, 1, 7'b001_0111);
      add(0, 0, 1, 1, 7, 6, 0, 7'b001_0111);
      add(0, 0, 1, 1, 7, 6, 0, 7'b001_1111);
      add(0, 0, 1, 1, 7, 6, 0, 7'b001_1111);
      add(0, 0, 1, 1, 7, 6, 0, 7'b001_1011);
      add(0, 0, 1, 1, 7, 6, 0, 7'b001_1011);
      add(0, 0, 1, 0, 0, 0, 1, 7'b011_0111);
      add(0, 0, 0, 0, 0, 0, 1, 7'b011_0111);
      add(0, 0, 0, 0, 7, 4, 0, 7'b011_0111);
      add(0, 0, 0, 0, 7, 4, 0, 7'b011_0101);
      add(0, 0, 0, 0, 7, 4, 0, 7'b111_0101);
      add(0, 0, 0, 0, 0, 0, 1, 7'b111_0111);
      add(0, 0, 0, 0, 0, 0, 1, 7'b111_0111);
      while (stim_q.size() != 0) begin
         v = stim_q.pop_front(); drive(v); exp_q.push_back(v.exp);
         @(posedge clk); #1;
         e = exp_q.pop_front(); got = {cpu_ipl_n, mfp_iack, dtack_n, vpa_n, berr_n};
         vectors++;
         if (got !== e) begin
            miscompares++;
            $display("FAIL mfp_vectored vec %0d: ipl/iack/dtack/vpa/berr got %b required %b", n, got, e);
         end
         n++;
      end
   endtask

   // Level 5 is spurious: bus error, HBL pend left intact.
   task automatic test_spurious();
      vec_t v; logic [6:0] e, got; int n = 0;
      add(0, 1, 0, 0, 0, 0, 1, 7'b111_0111);
      add(0, 1, 0, 0, 0, 0, 1, 7'b101_0111);
      add(0, 0, 0, 0, 7, 5, 0, 7'b101_0111);
      add(0, 0, 0, 0, 7, 5, 0, 7'b101_0110);
      add(0, 0, 0, 0, 7, 5, 0, 7'b101_0110);
      add(0, 0, 0, 0, 0, 0, 1, 7'b101_0111);
      add(0, 0, 0, 0, 0, 0, 1, 7'b101_0111);
      while (stim_q.size() != 0) begin
         v = stim_q.pop_front(); drive(v); exp_q.push_back(v.exp);
         @(posedge clk); #1;
         e = exp_q.pop_front(); got = {cpu_ipl_n, mfp_iack, dtack_n, vpa_n, berr_n};
         vectors++;
         if (got !== e) begin
            miscompares++;
            $display("FAIL spurious vec %0d: ipl/iack/dtack/vpa/berr got %b required %b", n, got, e);
         end
         n++;
      end
   endtask

   // New HBL edge in the DECODE cycle that clears HBL: the set wins.
   task automatic test_set_wins();
      vec_t v; logic [6:0] e, got; int n = 0;
      add(0, 0, 0, 0, 7, 2, 0, 7'b101_0111);
      add(0, 1, 0, 0, 7, 2, 0, 7'b101_0101);
      add(0, 1, 0, 0, 7, 2, 0, 7'b101_0101);
      add(0, 0, 0, 0, 0, 0, 1, 7'b101_0111);
      add(0, 0, 0, 0, 0, 0, 1, 7'b101_0111);
      while (stim_q.size() != 0) begin
         v = stim_q.pop_front(); drive(v); exp_q.push_back(v.exp);
         @(posedge clk); #1;
         e = exp_q.pop_front(); got = {cpu_ipl_n, mfp_iack, dtack_n, vpa_n, berr_n};
         vectors++;
         if (got !== e) begin
            miscompares++;
            $display("FAIL set_wins vec %0d: ipl/iack/dtack/vpa/berr got %b required %b", n, got, e);
         end
         n++;
      end
   endtask

   // AS held low on a level-6 ack: berr 31 cycles after entering MFP_WAIT.
   task automatic test_timeout();
      vec_t v; logic [6:0] e, got; int n = 0;
      add(0, 0, 0, 0, 7, 6, 0, 7'b101_0111);
      add(0, 0, 0, 0, 7, 6, 0, 7'b101_1111);
      add(0, 0, 0, 0, 7, 6, 0, 7'b101_1111);
      for (int i = 0; i < 29; i++)
         add(0, 0, 0, 0, 7, 6, 0, 7'b101_1011);
      add(0, 0, 0, 0, 7, 6, 0, 7'b101_0110);
      add(0, 0, 0, 0, 7, 6, 0, 7'b101_0110);
      add(0, 0, 0, 0, 7, 6, 0, 7'b101_0110);
      add(0, 0, 0, 0, 0, 0, 1, 7'b101_0111);
      add(0, 0, 0, 0, 0, 0, 1, 7'b101_0111);
      while (stim_q.size() != 0) begin
         v = stim_q.pop_front(); drive(v); exp_q.push_back(v.exp);
         @(posedge clk); #1;
         e = exp_q.pop_front(); got = {cpu_ipl_n, mfp_iack, dtack_n, vpa_n, berr_n};
         vectors++;
         if (got !== e) begin
            miscompares++;
            $display("FAIL timeout vec %0d: ipl/iack/dtack/vpa/berr got %b required %b", n, got, e);
         end
         n++;
      end
   endtask

   // Reset during MFP_ACK with hbl_in held high across release.
   task automatic test_reset_mid_cycle();
      vec_t v; logic [6:0] e, got; int n = 0;
      add(0, 0, 0, 1, 7, 6, 0, 7'b001_0111);
      add(0, 0, 0, 1, 7, 6, 0, 7'b001_1111);
      add(0, 0, 0, 1, 7, 6, 0, 7'b001_1111);
      add(0, 0, 0, 1, 7, 6, 0, 7'b001_1011);
      add(1, 1, 0, 1, 7, 6, 0, 7'b111_0111);
      add(0, 1, 0, 0, 0, 0, 1, 7'b111_0111);
      add(0, 1, 0, 0, 0, 0, 1, 7'b111_0111);
      add(0, 1, 0, 0, 0, 0, 1, 7'b111_0111);
      add(0, 0, 0, 0, 0, 0, 1, 7'b111_0111);
      while (stim_q.size() != 0) begin
         v = stim_q.pop_front(); drive(v); exp_q.push_back(v.exp);
         @(posedge clk); #1;
         e = exp_q.pop_front(); got = {cpu_ipl_n, mfp_iack, dtack_n, vpa_n, berr_n};
         vectors++;
         if (got !== e) begin
            miscompares++;
            $display("FAIL reset_mid_cycle vec %0d: ipl/iack/dtack/vpa/berr got %b required %b", n, got, e);
         end
         n++;
      end
   endtask

   initial begin
      reset = 1'b1; hbl_in = 1'b0; vbl_in = 1'b0; mfp_irq = 1'b0;
      cpu_fc = 3'd0; cpu_addr = 3'd0; cpu_as_n = 1'b1;
      test_reset();
      test_hbl_auto();
      test_mfp_vectored();
      test_spurious();
      test_set_wins();
      test_timeout();
      test_reset_mid_cycle();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/st_irq_arbiter.md
Name: st_irq_arbiter

Overview:
- Interrupt arbiter and acknowledge sequencer between the 68000 core, the MFP, and the video timing (HBL/VBL). This is the GLUE interrupt function of the Atari ST.
- Latches HBL/VBL events and encodes them, together with the MFP level irq, onto the CPU IPL lines.
- Decodes CPU interrupt-acknowledge cycles. Level 6 is routed to the MFP iack input, which supplies a vectored response. Levels 2 and 4 are answered with autovector (VPA). Any other level is answered with bus error.

Parameters:
- IACK_WAIT, 2: clk cycles mfp_iack is held before dtack_n is asserted, so the MFP vector output settles.
- ACK_TIMEOUT, 31: clk cycles in an ack state with cpu_as_n still low before the cycle is force-ended with berr_n.

Ports:
- clk, input, 1: system clock; all logic on posedge.
- reset, input, 1: reset, synchronous, active-high.
- hbl_in, input, 1: horizontal blank from video; rising edge = event.
- vbl_in, input, 1: vertical blank from video; rising edge = event.
- mfp_irq, input, 1: MFP interrupt request, level, active-high.
- cpu_fc, input, 3: CPU function code.
- cpu_addr, input, 3: CPU A[3:1]; the acknowledged level during an iack cycle.
- cpu_as_n, input, 1: CPU address strobe, active-low.
- cpu_ipl_n, output, 3: encoded interrupt priority level to CPU, active-low.
- mfp_iack, output, 1: MFP acknowledge, active-high.
- dtack_n, output, 1: DTACK for the MFP vector read, active-low.
- vpa_n, output, 1: autovector request, active-low.
- berr_n, output, 1: bus error for spurious or timed-out iack, active-low.

Behaviour:
- Reset values:
  - cpu_ipl_n=3'b111; mfp_iack=0; dtack_n=1; vpa_n=1; berr_n=1.
  - hbl_pend=0; vbl_pend=0; FSM=IDLE.
  - Edge-detect registers are loaded with the current inputs during reset, so no spurious edge appears after reset.
- Edge detect:
  - hbl_pend is set one cycle after a 0->1 transition of hbl_in.
  - vbl_pend is set the same way from vbl_in.
  - If set and clear occur in the same cycle, set wins.
- IPL encode, registered, 1-cycle latency from the pend/mfp_irq change:
  - level = mfp_irq ? 6 : vbl_pend ? 4 : hbl_pend ? 2 : 0.
  - cpu_ipl_n = ~level.
- iack_cyc = (cpu_fc==3'b111) && !cpu_as_n.
- FSM:
  - IDLE: on iack_cyc go to DECODE.
  - DECODE (one cycle; samples cpu_addr):
    - 6 -> MFP_WAIT: assert mfp_iack.
    - 4 -> AUTO: clear vbl_pend, assert vpa_n=0.
    - 2 -> AUTO: clear hbl_pend, assert vpa_n=0.
    - Any other value -> SPUR: assert berr_n=0.
  - MFP_WAIT: hold mfp_iack; after IACK_WAIT cycles go to MFP_ACK and assert dtack_n=0.
  - MFP_ACK, AUTO, SPUR: hold their outputs until cpu_as_n=1, then go to DONE.
  - DONE (one cycle): all outputs deasserted; go to IDLE. Two back-to-back iack cycles therefore have at least one idle clk between them.
- Timeout: if ACK_TIMEOUT cycles elapse in MFP_WAIT, MFP_ACK or AUTO with cpu_as_n still low, drop dtack_n/vpa_n, assert berr_n=0, and go to SPUR.
- Abort: if cpu_as_n rises in DECODE or MFP_WAIT, go directly to DONE with no dtack_n. Pend flags already cleared stay cleared.
- mfp_iack stays high for the whole MFP_WAIT and MFP_ACK span. It is continuous, so the MFP sees exactly one rising edge per acknowledged cycle.
- The MFP vector read has no pend flag to clear. The MFP clears its own IPR on iack.
- During an iack cycle the IPL keeps tracking inputs; it is not frozen.
- Reset asserted mid-cycle forces all reset values on the next edge, regardless of state.

Test Plan:
- hbl_in rising edge, no other sources -> cpu_ipl_n=3'b101 two cycles after the edge. Then iack cycle with fc=7, addr=2 -> vpa_n=0 from the cycle after DECODE; hbl_pend=0; cpu_ipl_n returns to 3'b111; vpa_n=1 after AS rises.
- mfp_irq=1 and vbl pending simultaneously -> cpu_ipl_n=3'b001. iack addr=6 -> mfp_iack=1; dtack_n=0 exactly IACK_WAIT cycles later; vbl_pend stays 1. After mfp_irq drops, cpu_ipl_n=3'b011.
- iack with addr=5 -> berr_n=0 until AS high; no change to pend flags; mfp_iack never asserted.
- New hbl_in edge in the same cycle as the level-2 DECODE clear -> hbl_pend remains 1 and the IPL stays at level 2 afterwards.
- iack addr=6 with cpu_as_n held low forever -> berr_n=0 at ACK_TIMEOUT cycles after entering MFP_WAIT; dtack_n=1 from then on.
- reset pulsed during MFP_ACK -> next cycle: mfp_iack=0, dtack_n=1, cpu_ipl_n=3'b111, FSM IDLE. With hbl_in held high through reset release, no hbl_pend is set.
